// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the LCD init sequencer.
//   - ROM entry layout: [10:9] opcode, [8:0] payload
//   - Serialiser word layout: [8] D/C (1 = data, 0 = command), [7:0] byte
//   - Sequencer state encoding
//   - Helpers used to build ROM entries readably
package lcd_pkg;

    localparam int unsigned ENTRY_W = 11;
    localparam int unsigned WORD_W  = 9;
    localparam int unsigned DC_BIT  = 8;
    localparam int unsigned ADDR_W  = 8;

    localparam logic [1:0] OP_SEND  = 2'b00;
    localparam logic [1:0] OP_DELAY = 2'b01;
    localparam logic [1:0] OP_END   = 2'b10;

    typedef enum logic [3:0] {
        StRstLow,
        StRstWait,
        StFetch,
        StDecode,
        StIssue,
        StWaitDone,
        StDelay,
        StReady,
        StRWait
    } state_e;

    function automatic logic [ENTRY_W-1:0] rom_cmd(input logic [7:0] b);
        return {OP_SEND, 1'b0, b};
    endfunction

    function automatic logic [ENTRY_W-1:0] rom_data(input logic [7:0] b);
        return {OP_SEND, 1'b1, b};
    endfunction

    function automatic logic [ENTRY_W-1:0] rom_send(input logic [WORD_W-1:0] w);
        return {OP_SEND, w};
    endfunction

    function automatic logic [ENTRY_W-1:0] rom_delay(input logic [7:0] units);
        return {OP_DELAY, 1'b0, units};
    endfunction

    function automatic logic [ENTRY_W-1:0] rom_end();
        return {OP_END, {WORD_W{1'b0}}};
    endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// lcd_init_rom: registered 256 x 11 init table (one cycle read latency).
//   clk   - clock
//   addr  - entry address, sampled every cycle
//   entry - entry at the address sampled on the previous edge
// Unlisted addresses read as END so a short table always terminates.
module lcd_init_rom
    import lcd_pkg::*;
(
    input  logic               clk,
    input  logic [ADDR_W-1:0]  addr,
    output logic [ENTRY_W-1:0] entry
);

    logic [ENTRY_W-1:0] rom_word;

    always_comb begin
        rom_word = rom_end();
        case (addr)
            8'd0:    rom_word = rom_send(9'h001);
            8'd1:    rom_word = rom_delay(8'd3);
            8'd2:    rom_word = rom_send(9'h111);
            8'd3:    rom_word = rom_delay(8'd0);
            8'd4:    rom_word = rom_send(9'h02C);
            8'd5:    rom_word = rom_end();
            default: rom_word = rom_end();
        endcase
    end

    always_ff @(posedge clk) begin
        entry <= rom_word;
    end

endmodule

// File: rtl/lcd_init_seq.sv
// lcd_init_seq: LCD command sequencer in front of the SPI serialiser.
// Pulses the panel reset, walks the init ROM (SEND / DELAY / END entries),
// then forwards upstream words to the serialiser with a valid/ready handshake.
//   clk, rst     - clock, synchronous active-high reset
//   lcd_rst_o    - panel hardware reset, active low
//   spi_en_o     - one-cycle start pulse to the serialiser
//   spi_data_o   - word to the serialiser ([8] D/C, [7:0] byte), held between issues
//   spi_done_i   - one-cycle completion pulse from the serialiser
//   in_valid_i   - upstream word valid
//   in_data_i    - upstream word
//   in_ready_o   - sequencer can accept an upstream word
//   init_done_o  - init table finished (level)
module lcd_init_seq
    import lcd_pkg::*;
#(
    parameter int unsigned RST_LOW_CYC    = 10000,
    parameter int unsigned RST_WAIT_CYC   = 120000,
    parameter int unsigned DELAY_UNIT_CYC = 50000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              lcd_rst_o,
    output logic              spi_en_o,
    output logic [WORD_W-1:0] spi_data_o,
    input  logic              spi_done_i,
    input  logic              in_valid_i,
    input  logic [WORD_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              init_done_o
);

    localparam logic [31:0]       RST_LOW_LAST  = 32'(RST_LOW_CYC - 1);
    localparam logic [31:0]       RST_WAIT_LAST = 32'(RST_WAIT_CYC - 1);
    localparam logic [31:0]       UNIT_LAST     = 32'(DELAY_UNIT_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST     = '1;

    state_e             state_q, state_d;
    logic [31:0]        cnt_q, cnt_d;     // reset-phase timer and delay prescaler
    logic [7:0]         unit_q, unit_d;   // remaining delay units
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [WORD_W-1:0]  data_q, data_d;
    logic               en_q, en_d;
    logic               lcd_rst_q;
    logic               step_done;        // current ROM entry finished
    logic [ENTRY_W-1:0] rom_entry;
    logic [1:0]         rom_op;

    lcd_init_rom u_rom (
        .clk   (clk),
        .addr  (addr_q),
        .entry (rom_entry)
    );

    assign rom_op = rom_entry[ENTRY_W-1 -: 2];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        unit_d    = unit_q;
        addr_d    = addr_q;
        data_d    = data_q;
        en_d      = 1'b0;
        step_done = 1'b0;

        unique case (state_q)
            StRstLow: begin
                if (cnt_q == RST_LOW_LAST) begin
                    state_d = StRstWait;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StRstWait: begin
                if (cnt_q == RST_WAIT_LAST) begin
                    state_d = StFetch;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            // ROM samples addr_q on the edge leaving FETCH.
            StFetch: state_d = StDecode;
            StDecode: begin
                case (rom_op)
                    OP_SEND: begin
                        state_d = StIssue;
                        en_d    = 1'b1;
                        data_d  = rom_entry[WORD_W-1:0];
                    end
                    OP_DELAY: begin
                        state_d = StDelay;
                        unit_d  = rom_entry[7:0];
                        cnt_d   = '0;
                    end
                    // OP_END and the reserved opcode both finish the table.
                    default: state_d = StReady;
                endcase
            end
            StIssue: state_d = StWaitDone;
            StWaitDone: begin
                if (spi_done_i) begin
                    step_done = 1'b1;
                end
            end
            StDelay: begin
                // Zero units leaves after this single cycle; otherwise stay
                // exactly units * DELAY_UNIT_CYC cycles.
                if (unit_q == 8'd0) begin
                    step_done = 1'b1;
                end else if (cnt_q == UNIT_LAST) begin
                    cnt_d  = '0;
                    unit_d = unit_q - 8'd1;
                    if (unit_q == 8'd1) begin
                        step_done = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StReady: begin
                if (in_valid_i) begin
                    state_d = StRWait;
                    en_d    = 1'b1;
                    data_d  = in_data_i;
                end
            end
            StRWait: begin
                if (spi_done_i) begin
                    state_d = StReady;
                end
            end
            default: state_d = StRstLow;
        endcase

        // The last address is executed but never wraps back to 0.
        if (step_done) begin
            if (addr_q == ADDR_LAST) begin
                state_d = StReady;
            end else begin
                addr_d  = addr_q + 1'b1;
                state_d = StFetch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRstLow;
            cnt_q     <= '0;
            unit_q    <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            en_q      <= 1'b0;
            lcd_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            unit_q    <= unit_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            en_q      <= en_d;
            lcd_rst_q <= (state_d != StRstLow);
        end
    end

    assign lcd_rst_o   = lcd_rst_q;
    assign spi_en_o    = en_q;
    assign spi_data_o  = data_q;
    assign in_ready_o  = (state_q == StReady);
    assign init_done_o = (state_q == StReady) || (state_q == StRWait);

endmodule

// File: tb/tb_lcd_init_seq.sv
module tb_lcd_init_seq;

    localparam int RL = 4;
    localparam int RW = 6;
    localparam int DU = 10;
    localparam int N_ROM = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lcd_rst_o;
    logic       spi_en_o;
    logic [8:0] spi_data_o;
    logic       spi_done_i;
    logic       in_valid_i = 1'b0;
    logic [8:0] in_data_i = 9'h0;
    logic       in_ready_o;
    logic       init_done_o;

    always #5 clk = ~clk;

    lcd_init_seq #(
        .RST_LOW_CYC    (RL),
        .RST_WAIT_CYC   (RW),
        .DELAY_UNIT_CYC (DU)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .lcd_rst_o   (lcd_rst_o),
        .spi_en_o    (spi_en_o),
        .spi_data_o  (spi_data_o),
        .spi_done_i  (spi_done_i),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .init_done_o (init_done_o)
    );

    // Expected init table: op 0 = SEND word, 1 = DELAY units, 2 = END.
    int         tb_op  [N_ROM] = '{0, 1, 0, 1, 0, 2};
    logic [8:0] tb_arg [N_ROM] = '{9'h001, 9'd3, 9'h111, 9'd0, 9'h02C, 9'd0};

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Serialiser model: done arrives ser_lat cycles after each start pulse.
    typedef struct {
        int         cyc;
        logic [8:0] data;
        int         lat;
    } en_ev_t;

    en_ev_t en_log[$];
    int     ser_lat = 20;
    int     ser_cnt = 0;
    logic   ser_abort = 1'b0;
    logic   model_done = 1'b0;
    logic   stray_done = 1'b0;

    assign spi_done_i = model_done | stray_done;

    always @(negedge clk) begin : ser_model
        en_ev_t ev;
        model_done = 1'b0;
        if (ser_abort) ser_cnt = 0;
        if (ser_cnt > 0) begin
            ser_cnt = ser_cnt - 1;
            if (ser_cnt == 0) model_done = 1'b1;
        end
        if (spi_en_o === 1'b1) begin
            ev.cyc  = cyc;
            ev.data = spi_data_o;
            ev.lat  = ser_lat;
            en_log.push_back(ev);
            ser_cnt = ser_lat;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset(input string tag);
        rst        = 1'b1;
        in_valid_i = 1'b0;
        stray_done = 1'b0;
        ser_abort  = 1'b1;
        tick();
        tick();
        checks++;
        if (lcd_rst_o !== 1'b0) begin
            errors++; $display("FAIL %s lcd_rst_o got %b want 0", tag, lcd_rst_o);
        end
        checks++;
        if (spi_en_o !== 1'b0) begin
            errors++; $display("FAIL %s spi_en_o got %b want 0", tag, spi_en_o);
        end
        checks++;
        if (spi_data_o !== 9'h000) begin
            errors++; $display("FAIL %s spi_data_o got %h want 000", tag, spi_data_o);
        end
        checks++;
        if (in_ready_o !== 1'b0) begin
            errors++; $display("FAIL %s in_ready_o got %b want 0", tag, in_ready_o);
        end
        checks++;
        if (init_done_o !== 1'b0) begin
            errors++; $display("FAIL %s init_done_o got %b want 0", tag, init_done_o);
        end
    endtask

    // Releases reset; stray done pulses and upstream valids must be ignored.
    task automatic test_power_up(output int rel);
        int rise = -1;
        int bad  = 0;
        rst       = 1'b0;
        ser_abort = 1'b0;
        rel       = cyc;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (spi_en_o !== 1'b0 || in_ready_o !== 1'b0 || init_done_o !== 1'b0) bad++;
            if (lcd_rst_o === 1'b1) begin
                rise = cyc;
                break;
            end
            stray_done = (i == 1) ? 1'b1 : 1'(($urandom % 2));
            in_valid_i = 1'($urandom % 2);
            in_data_i  = 9'($urandom);
        end
        stray_done = 1'b0;
        checks++;
        if (rise - rel != RL) begin
            errors++; $display("FAIL lcd_rst_rise got %0d want %0d", rise - rel, RL);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL power_up_quiet got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_init_sequence(input int rel);
        int base = en_log.size();
        int ready_cyc = -1;
        int bad = 0;
        int f, k, n_send, exp_ready;
        ser_lat = 20;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (init_done_o === 1'b1) begin
                ready_cyc = cyc;
                break;
            end
            if (in_ready_o !== 1'b0) bad++;
            in_valid_i = 1'($urandom % 2);
            in_data_i  = 9'($urandom);
        end
        in_valid_i = 1'b0;
        checks++;
        if (in_ready_o !== 1'b1) begin
            errors++; $display("FAIL ready_with_done got %b want 1", in_ready_o);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL ready_during_init got %0d cycles want 0", bad);
        end

        // Walk the table: FETCH at f, DECODE at f+1, action at f+2.
        f = rel + RL + RW;
        k = base;
        n_send = 0;
        exp_ready = -1;
        for (int i = 0; i < N_ROM; i++) begin
            if (tb_op[i] == 0) begin
                n_send++;
                checks++;
                if (k >= en_log.size()) begin
                    errors++; $display("FAIL send%0d_missing got none want %h", i, tb_arg[i]);
                    f = f + 2 + ser_lat + 1;
                end else begin
                    if (en_log[k].cyc != f + 2 || en_log[k].data !== tb_arg[i]) begin
                        errors++;
                        $display("FAIL send%0d got %h@%0d want %h@%0d", i, en_log[k].data,
                                 en_log[k].cyc - rel, tb_arg[i], f + 2 - rel);
                    end
                    f = f + 2 + en_log[k].lat + 1;
                end
                k++;
            end else if (tb_op[i] == 1) begin
                f = f + 2 + ((tb_arg[i] == 9'd0) ? 1 : int'(tb_arg[i]) * DU);
            end else begin
                exp_ready = f + 2;
                break;
            end
        end
        checks++;
        if (en_log.size() - base != n_send) begin
            errors++; $display("FAIL send_count got %0d want %0d", en_log.size() - base, n_send);
        end
        checks++;
        if (ready_cyc - rel != exp_ready - rel) begin
            errors++; $display("FAIL init_done_cycle got %0d want %0d", ready_cyc - rel,
                               exp_ready - rel);
        end
    endtask

    task automatic test_spurious_done();
        int base = en_log.size();
        int bad = 0;
        tick();
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        repeat (5) begin
            tick();
            if (in_ready_o !== 1'b1 || init_done_o !== 1'b1) bad++;
        end
        checks++;
        if (en_log.size() != base) begin
            errors++; $display("FAIL spurious_done_en got %0d want 0", en_log.size() - base);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL spurious_done_ready got %0d bad want 0", bad);
        end
    endtask

    task automatic test_hold_valid();
        int base, a, r = -1, low = 0;
        ser_lat = 20;
        tick();
        base = en_log.size();
        a = cyc;
        in_valid_i = 1'b1;
        in_data_i  = 9'h1A5;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (in_ready_o === 1'b0) low++;
        end
        in_valid_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (in_ready_o === 1'b1) begin
                r = cyc;
                break;
            end
            tick();
        end
        checks++;
        if (en_log.size() - base != 1) begin
            errors++; $display("FAIL hold_accepts got %0d want 1", en_log.size() - base);
        end
        checks++;
        if (en_log.size() <= base || en_log[base].data !== 9'h1A5 || en_log[base].cyc != a + 1)
        begin
            errors++; $display("FAIL hold_en got %0d pulses want 1A5 at +1", en_log.size() - base);
        end
        checks++;
        if (low != 3 || r != a + 2 + 20) begin
            errors++; $display("FAIL hold_ready got low %0d back %0d want 3 %0d", low, r - a, 22);
        end
    endtask

    task automatic test_stream();
        int base, a, r, lat;
        logic [8:0] w;
        for (int n = 0; n < 16; n++) begin
            lat = int'($urandom_range(1, 12));
            ser_lat = lat;
            repeat ($urandom_range(0, 3)) tick();
            base = en_log.size();
            w = 9'($urandom);
            a = cyc;
            in_valid_i = 1'b1;
            in_data_i  = w;
            tick();
            in_valid_i = 1'b0;
            r = -1;
            for (int i = 0; i < 100; i++) begin
                if (in_ready_o === 1'b1) begin
                    r = cyc;
                    break;
                end
                tick();
            end
            checks++;
            if (en_log.size() - base != 1 || en_log[base].data !== w) begin
                errors++; $display("FAIL stream%0d_word got %0d pulses want %h", n,
                                   en_log.size() - base, w);
            end
            checks++;
            if (en_log.size() <= base || en_log[base].cyc != a + 1) begin
                errors++; $display("FAIL stream%0d_latency want en at +1", n);
            end
            checks++;
            if (r != a + 2 + lat) begin
                errors++; $display("FAIL stream%0d_ready got %0d want %0d", n, r - a, 2 + lat);
            end
        end
    endtask

    task automatic test_reset_mid_transfer();
        int rel, base, seen = 0;
        test_reset("pre_mid_reset");
        test_power_up(rel);
        ser_lat = 20;
        base = en_log.size();
        for (int i = 0; i < 100; i++) begin
            tick();
            if (en_log.size() > base) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (seen != 1) begin
            errors++; $display("FAIL mid_first_send got none want one");
        end
        repeat (3) tick();
        test_reset("mid_reset");
        test_power_up(rel);
        test_init_sequence(rel);
    endtask

    initial begin
        int rel;
        test_reset("reset");
        test_power_up(rel);
        test_init_sequence(rel);
        test_spurious_done();
        test_hold_valid();
        test_stream();
        test_reset_mid_transfer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lcd_init_seq.md
# lcd_init_seq

- Command sequencer directly upstream of the LCD SPI serialiser (`spi_driver`).
- After reset it pulses the panel hardware reset, then walks an init ROM, issuing 9-bit command/data words one at a time and honouring embedded millisecond delays.
- Once the table ends it becomes a pass-through, forwarding upstream command/pixel words to the serialiser through a valid/ready handshake.

## Interface
- `RST_LOW_CYC`, default 10000: cycles `lcd_rst_o` is held low.
- `RST_WAIT_CYC`, default 120000: cycles waited after `lcd_rst_o` rises, before the first ROM fetch.
- `DELAY_UNIT_CYC`, default 50000: cycles per delay unit (1 ms at 50 MHz).
- `clk` input 1: sole clock.
- `rst` input 1: synchronous, active-high reset.
- `lcd_rst_o` output 1: panel hardware reset, active low.
- `spi_en_o` output 1: one-cycle start pulse to the serialiser.
- `spi_data_o` output 9: word to the serialiser; bit 8 = D/C (1 data, 0 command), bits 7:0 = byte.
- `spi_done_i` input 1: one-cycle completion pulse from the serialiser.
- `in_valid_i` input 1: upstream word valid.
- `in_data_i` input 9: upstream word, same format as `spi_data_o`.
- `in_ready_o` output 1: sequencer can accept an upstream word.
- `init_done_o` output 1: level; init table finished.

## Operation
- ROM entry format is 11 bits.
  - `[10:9]` opcode: 00 = SEND, 01 = DELAY, 10 = END, 11 = treated as END.
  - `[8:0]` payload: the word for SEND; `[7:0]` = delay units for DELAY.
- States:
  - RST_LOW → RST_WAIT: after `RST_LOW_CYC` cycles.
  - RST_WAIT → FETCH: after `RST_WAIT_CYC` cycles.
  - FETCH → DECODE: unconditional.
  - DECODE → ISSUE (SEND), DELAY (DELAY), or READY (END).
  - ISSUE → WAIT_DONE: unconditional.
  - WAIT_DONE → FETCH on `spi_done_i`; the ROM address increments.
  - DELAY → FETCH when the count expires; the ROM address increments.
  - READY: streaming.
  - READY → R_WAIT on an accepted word; R_WAIT → READY on `spi_done_i`.
- ISSUE drives `spi_en_o`=1 for exactly one cycle, with `spi_data_o` = payload.
  - `spi_data_o` holds that value until the next issue.
- DELAY with payload 0: proceeds to FETCH on the next cycle.
  - Otherwise the wait is payload×`DELAY_UNIT_CYC` cycles, implemented as a prescaler plus an 8-bit unit down-counter.
- READY: `in_ready_o`=1.
  - An accept is `in_valid_i & in_ready_o`.
  - On accept: `spi_data_o` ← `in_data_i`, `spi_en_o` pulses in the next cycle, and `in_ready_o` drops until `spi_done_i`.
- `spi_done_i` is ignored outside WAIT_DONE and R_WAIT.
- `in_valid_i` is ignored before READY; `in_ready_o`=0 there.
- ROM address is 8 bits. If the address reaches 255 without END, the entry at 255 is executed and the sequencer then enters READY; no wrap.
- Reset outputs: `lcd_rst_o`=0, `spi_en_o`=0, `spi_data_o`=0, `in_ready_o`=0, `init_done_o`=0. State = RST_LOW, ROM address = 0.
- Reset mid-transfer aborts the transfer and restarts the full sequence. A later `spi_done_i` is then ignored by the RST_* states.

## Timing
- `rst` sampled high at edge E0 sets the reset values above.
- `lcd_rst_o` rises `RST_LOW_CYC` cycles after the first edge with `rst` low.
- First FETCH is `RST_WAIT_CYC` cycles after the rise.
- ROM read latency is 1 cycle: FETCH addresses, DECODE consumes.
- SEND timing: `spi_en_o` is high 2 cycles after FETCH entry.
- Next FETCH is the cycle after `spi_done_i`.
- Streaming accept-to-`spi_en_o` latency: 1 cycle.
- Maximum streaming rate: one word per serialiser transaction plus 2 cycles.
- `init_done_o` rises on entry to READY, in the same cycle as `in_ready_o` first goes high.

## Structure
- Shared package `lcd_pkg` holds:
  - opcode constants OP_SEND / OP_DELAY / OP_END;
  - the entry width (11) and word width (9);
  - the D/C bit index (8);
  - the state encoding.
- Sub-module `lcd_init_rom`: registered 256×11 ROM, case-statement contents, addr in / entry out.

## Test plan
- RST_LOW_CYC=4, RST_WAIT_CYC=6: release `rst` → `lcd_rst_o` low exactly 4 cycles, first ROM address 0 presented 6 cycles after the rise.
- ROM {SEND 9'h001, DELAY 3, SEND 9'h111, END}, DELAY_UNIT_CYC=10, serialiser model returns done after 20 cycles:
  - `spi_en_o` pulses with data 9'h001, then 9'h111;
  - 30 cycles of delay between the two transactions;
  - `init_done_o`=1 afterwards.
- DELAY 0 entry → next FETCH on the following cycle, with no extra wait.
- In READY, assert `in_valid_i` with 9'h1A5 held for 3 cycles:
  - exactly one accept;
  - `spi_en_o` pulses with 9'h1A5 one cycle later;
  - `in_ready_o` is low until done.
- Assert `rst` during WAIT_DONE, then a stray `spi_done_i` → outputs return to reset values, the stray done is ignored, and the sequence restarts from address 0.
- Spurious `spi_done_i` in READY, and `in_valid_i` during init → no state change, no `spi_en_o`.
